// File: rtl/ptp_pkg.sv
// Shared PTP time-of-day definitions: 96-bit field layout, widths and the
// seconds rollover constant used by the ToD generator and its helpers.
package ptp_pkg;

  localparam int SEC_W = 48;
  localparam int NS_W  = 32;
  localparam int FNS_W = 16;

  localparam int SEC_MSB = 95;
  localparam int SEC_LSB = 48;
  localparam int NS_MSB  = 47;
  localparam int NS_LSB  = 16;
  localparam int FNS_MSB = 15;
  localparam int FNS_LSB = 0;

  localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
    logic [FNS_W-1:0] fns;
  } tod_t;

endpackage

// File: rtl/ptp_tod_incr.sv
// Combinational ToD adder: adds a signed {ns,fns} increment and applies at most
// one seconds rollover or borrow, with 48-bit modulo seconds.
module ptp_tod_incr
  import ptp_pkg::*;
#(
  parameter int INC_W = 50
) (
  input  tod_t                    tod_i,
  input  logic signed [INC_W-1:0] inc_i,
  output tod_t                    tod_o,
  output logic                    rollover_o,
  output logic                    borrow_o
);

  localparam int SUM_W = INC_W + 2;

  logic signed [SUM_W-1:0] curVal;
  logic signed [SUM_W-1:0] incVal;
  logic signed [SUM_W-1:0] sumVal;
  logic signed [SUM_W-1:0] sumNs;
  logic signed [SUM_W-1:0] nsLimit;
  logic signed [SUM_W-1:0] nsPlus;
  logic signed [SUM_W-1:0] nsMinus;

  assign curVal  = {{(SUM_W-NS_W-FNS_W){1'b0}}, tod_i.ns, tod_i.fns};
  assign incVal  = {{2{inc_i[INC_W-1]}}, inc_i};
  assign sumVal  = curVal + incVal;
  assign sumNs   = sumVal >>> FNS_W;
  assign nsLimit = {{(SUM_W-NS_W){1'b0}}, NS_PER_SEC};
  assign nsPlus  = sumNs + nsLimit;
  assign nsMinus = sumNs - nsLimit;

  // Adding or removing whole seconds never disturbs the fractional field.
  always_comb begin
    tod_o.sec  = tod_i.sec;
    tod_o.ns   = sumNs[NS_W-1:0];
    tod_o.fns  = sumVal[FNS_W-1:0];
    rollover_o = 1'b0;
    borrow_o   = 1'b0;
    if (sumVal[SUM_W-1]) begin
      tod_o.ns  = nsPlus[NS_W-1:0];
      tod_o.sec = tod_i.sec - 48'd1;
      borrow_o  = 1'b1;
    end else if (sumNs >= nsLimit) begin
      tod_o.ns   = nsMinus[NS_W-1:0];
      tod_o.sec  = tod_i.sec + 48'd1;
      rollover_o = 1'b1;
    end
  end

endmodule

// File: rtl/ptp_tod_source.sv
// Free-running 96-bit PTP time-of-day source with time set, period trim,
// slewed offset adjustment and fixed drift compensation.
module ptp_tod_source
  import ptp_pkg::*;
#(
  parameter int                         PERIOD_NS_WIDTH = 4,
  parameter int                         OFFSET_NS_WIDTH = 32,
  parameter int                         FNS_WIDTH       = 16,
  parameter logic [PERIOD_NS_WIDTH-1:0] PERIOD_NS       = 4'h6,
  parameter logic [FNS_WIDTH-1:0]       PERIOD_FNS      = 16'h6666,
  parameter int                         DRIFT_ENABLE    = 1,
  parameter logic [PERIOD_NS_WIDTH-1:0] DRIFT_NS        = 4'h0,
  parameter logic [FNS_WIDTH-1:0]       DRIFT_FNS       = 16'h0002,
  parameter logic [15:0]                DRIFT_RATE      = 16'h0005
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [95:0]                input_ts_96,
  input  logic                       input_ts_96_valid,
  input  logic [PERIOD_NS_WIDTH-1:0] input_period_ns,
  input  logic [FNS_WIDTH-1:0]       input_period_fns,
  input  logic                       input_period_valid,
  input  logic [OFFSET_NS_WIDTH-1:0] input_adj_ns,
  input  logic [FNS_WIDTH-1:0]       input_adj_fns,
  input  logic [15:0]                input_adj_count,
  input  logic                       input_adj_valid,
  output logic                       output_adj_active,
  output logic [95:0]                output_ts_96,
  output logic                       output_ts_step,
  output logic                       output_pps
);

  localparam int INC_W = OFFSET_NS_WIDTH + FNS_WIDTH + 2;
  localparam int PAD_W = INC_W - PERIOD_NS_WIDTH - FNS_WIDTH;
  localparam logic [INC_W-1:0] DRIFT_INC = {{PAD_W{1'b0}}, DRIFT_NS, DRIFT_FNS};

  tod_t                       tod_q, tod_d;
  logic                       step_q, step_d;
  logic                       pps_q, pps_d;
  logic [PERIOD_NS_WIDTH-1:0] periodNs_q, periodNs_d;
  logic [FNS_WIDTH-1:0]       periodFns_q, periodFns_d;
  logic [15:0]                driftCnt_q, driftCnt_d;
  logic [OFFSET_NS_WIDTH-1:0] adjNs_q, adjNs_d;
  logic [FNS_WIDTH-1:0]       adjFns_q, adjFns_d;
  logic [15:0]                adjCount_q, adjCount_d;

  logic                       driftWrap;
  logic                       driftHit;
  logic                       adjActive;
  logic                       adjStart;
  logic                       applyAdj;
  logic signed [INC_W-1:0]    periodInc;
  logic signed [INC_W-1:0]    adjInc;
  logic signed [INC_W-1:0]    totalInc;
  tod_t                       incrTod;
  logic                       incrRollover;
  logic                       incrBorrow;

  assign driftWrap = (driftCnt_q == DRIFT_RATE - 16'd1);
  assign driftHit  = (DRIFT_ENABLE != 0) && driftWrap;
  assign adjActive = (adjCount_q != 16'd0);
  assign adjStart  = input_adj_valid && (input_adj_count != 16'd0);
  // A restart discards the old adjustment, so nothing is applied on that cycle.
  assign applyAdj  = adjActive && !adjStart;

  assign periodInc = {{PAD_W{1'b0}}, periodNs_q, periodFns_q};
  assign adjInc    = {{(INC_W-OFFSET_NS_WIDTH-FNS_WIDTH){adjNs_q[OFFSET_NS_WIDTH-1]}},
                      adjNs_q, adjFns_q};
  assign totalInc  = periodInc + (driftHit ? DRIFT_INC : '0) + (applyAdj ? adjInc : '0);

  ptp_tod_incr #(
    .INC_W (INC_W)
  ) u_incr (
    .tod_i      (tod_q),
    .inc_i      (totalInc),
    .tod_o      (incrTod),
    .rollover_o (incrRollover),
    .borrow_o   (incrBorrow)
  );

  // A time set wins over everything else and also cancels any adjustment.
  always_comb begin
    tod_d       = incrTod;
    step_d      = 1'b0;
    pps_d       = incrRollover;
    periodNs_d  = periodNs_q;
    periodFns_d = periodFns_q;
    driftCnt_d  = driftWrap ? 16'd0 : driftCnt_q + 16'd1;
    adjNs_d     = adjNs_q;
    adjFns_d    = adjFns_q;
    adjCount_d  = adjActive ? adjCount_q - 16'd1 : 16'd0;
    if (input_period_valid) begin
      periodNs_d  = input_period_ns;
      periodFns_d = input_period_fns;
    end
    if (adjStart) begin
      adjNs_d    = input_adj_ns;
      adjFns_d   = input_adj_fns;
      adjCount_d = input_adj_count;
    end
    if (input_ts_96_valid) begin
      tod_d      = input_ts_96;
      step_d     = 1'b1;
      pps_d      = 1'b0;
      adjCount_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tod_q       <= '0;
      step_q      <= 1'b0;
      pps_q       <= 1'b0;
      periodNs_q  <= PERIOD_NS;
      periodFns_q <= PERIOD_FNS;
      driftCnt_q  <= 16'd0;
      adjNs_q     <= '0;
      adjFns_q    <= '0;
      adjCount_q  <= 16'd0;
    end else begin
      tod_q       <= tod_d;
      step_q      <= step_d;
      pps_q       <= pps_d;
      periodNs_q  <= periodNs_d;
      periodFns_q <= periodFns_d;
      driftCnt_q  <= driftCnt_d;
      adjNs_q     <= adjNs_d;
      adjFns_q    <= adjFns_d;
      adjCount_q  <= adjCount_d;
    end
  end

  assign output_ts_96      = tod_q;
  assign output_ts_step    = step_q;
  assign output_pps        = pps_q;
  assign output_adj_active = adjActive;

endmodule

// File: tb/tb_ptp_tod_source.sv
// Directed self-checking bench for ptp_tod_source: one drift-enabled instance
// and one with drift disabled, both driven by the same stimulus.
module tb_ptp_tod_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] input_ts_96 = '0;
  logic        input_ts_96_valid = 1'b0;
  logic [3:0]  input_period_ns = '0;
  logic [15:0] input_period_fns = '0;
  logic        input_period_valid = 1'b0;
  logic [31:0] input_adj_ns = '0;
  logic [15:0] input_adj_fns = '0;
  logic [15:0] input_adj_count = '0;
  logic        input_adj_valid = 1'b0;

  logic        actD, stepD, ppsD;
  logic [95:0] tsD;
  logic        actN, stepN, ppsN;
  logic [95:0] tsN;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ptp_tod_source dut (
    .clk (clk), .rst (rst),
    .input_ts_96 (input_ts_96), .input_ts_96_valid (input_ts_96_valid),
    .input_period_ns (input_period_ns), .input_period_fns (input_period_fns),
    .input_period_valid (input_period_valid),
    .input_adj_ns (input_adj_ns), .input_adj_fns (input_adj_fns),
    .input_adj_count (input_adj_count), .input_adj_valid (input_adj_valid),
    .output_adj_active (actD), .output_ts_96 (tsD),
    .output_ts_step (stepD), .output_pps (ppsD)
  );

  ptp_tod_source #(.DRIFT_ENABLE(0)) dutNd (
    .clk (clk), .rst (rst),
    .input_ts_96 (input_ts_96), .input_ts_96_valid (input_ts_96_valid),
    .input_period_ns (input_period_ns), .input_period_fns (input_period_fns),
    .input_period_valid (input_period_valid),
    .input_adj_ns (input_adj_ns), .input_adj_fns (input_adj_fns),
    .input_adj_count (input_adj_count), .input_adj_valid (input_adj_valid),
    .output_adj_active (actN), .output_ts_96 (tsN),
    .output_ts_step (stepN), .output_pps (ppsN)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (tsN !== 96'd0) begin mismatched++; $display("[TB] FAIL reset_ts actual=%h required=%h", tsN, 96'd0); end
    compared++; if (tsD !== 96'd0) begin mismatched++; $display("[TB] FAIL reset_ts_drift actual=%h required=%h", tsD, 96'd0); end
    compared++; if ({stepN, ppsN, actN} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags actual=%b required=000", {stepN, ppsN, actN}); end
    rst = 1'b0;
    tick();
    compared++; if (tsN !== {48'd0, 32'd6, 16'h6666}) begin mismatched++; $display("[TB] FAIL reset_first actual=%h required=%h", tsN, {48'd0, 32'd6, 16'h6666}); end
    tick();
    compared++; if (tsN !== {48'd0, 32'd12, 16'hCCCC}) begin mismatched++; $display("[TB] FAIL reset_second actual=%h required=%h", tsN, {48'd0, 32'd12, 16'hCCCC}); end
  endtask

  task automatic test_rollover();
    doReset();
    input_ts_96 = {48'd5, 32'd999_999_990, 16'h0000};
    input_ts_96_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    compared++; if (tsN !== {48'd5, 32'd999_999_990, 16'h0000}) begin mismatched++; $display("[TB] FAIL roll_set actual=%h required=%h", tsN, {48'd5, 32'd999_999_990, 16'h0000}); end
    compared++; if ({stepN, ppsN} !== 2'b10) begin mismatched++; $display("[TB] FAIL roll_set_flags actual=%b required=10", {stepN, ppsN}); end
    tick();
    compared++; if (tsN !== {48'd5, 32'd999_999_996, 16'h6666}) begin mismatched++; $display("[TB] FAIL roll_pre actual=%h required=%h", tsN, {48'd5, 32'd999_999_996, 16'h6666}); end
    compared++; if ({stepN, ppsN} !== 2'b00) begin mismatched++; $display("[TB] FAIL roll_pre_flags actual=%b required=00", {stepN, ppsN}); end
    tick();
    compared++; if (tsN !== {48'd6, 32'd2, 16'hCCCC}) begin mismatched++; $display("[TB] FAIL roll_over actual=%h required=%h", tsN, {48'd6, 32'd2, 16'hCCCC}); end
    compared++; if (ppsN !== 1'b1) begin mismatched++; $display("[TB] FAIL roll_pps actual=%b required=1", ppsN); end
    tick();
    compared++; if (ppsN !== 1'b0) begin mismatched++; $display("[TB] FAIL roll_pps_drop actual=%b required=0", ppsN); end
    compared++; if (tsN !== {48'd6, 32'd9, 16'h3332}) begin mismatched++; $display("[TB] FAIL roll_after actual=%h required=%h", tsN, {48'd6, 32'd9, 16'h3332}); end
  endtask

  task automatic test_drift();
    doReset();
    for (int i = 0; i < 4; i++) tick();
    compared++; if (tsD !== {48'd0, 32'd25, 16'h9998}) begin mismatched++; $display("[TB] FAIL drift_pre actual=%h required=%h", tsD, {48'd0, 32'd25, 16'h9998}); end
    tick();
    compared++; if (tsD !== {48'd0, 32'd32, 16'h0000}) begin mismatched++; $display("[TB] FAIL drift_event actual=%h required=%h", tsD, {48'd0, 32'd32, 16'h0000}); end
    tick();
    compared++; if (tsD !== {48'd0, 32'd38, 16'h6666}) begin mismatched++; $display("[TB] FAIL drift_after actual=%h required=%h", tsD, {48'd0, 32'd38, 16'h6666}); end
  endtask

  task automatic test_adjust();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    input_adj_ns = 32'd1;
    input_adj_fns = 16'h0000;
    input_adj_count = 16'd3;
    input_adj_valid = 1'b1;
    tick();
    input_adj_valid = 1'b0;
    compared++; if (tsN[47:0] !== {32'd6, 16'h6666} || actN !== 1'b1) begin mismatched++; $display("[TB] FAIL adj_start actual=%h/%b required=%h/1", tsN[47:0], actN, {32'd6, 16'h6666}); end
    tick();
    compared++; if (tsN[47:0] !== {32'd13, 16'hCCCC} || actN !== 1'b1) begin mismatched++; $display("[TB] FAIL adj_first actual=%h/%b required=%h/1", tsN[47:0], actN, {32'd13, 16'hCCCC}); end
    tick();
    compared++; if (tsN[47:0] !== {32'd21, 16'h3332} || actN !== 1'b1) begin mismatched++; $display("[TB] FAIL adj_second actual=%h/%b required=%h/1", tsN[47:0], actN, {32'd21, 16'h3332}); end
    tick();
    compared++; if (tsN[47:0] !== {32'd28, 16'h9998} || actN !== 1'b0) begin mismatched++; $display("[TB] FAIL adj_third actual=%h/%b required=%h/0", tsN[47:0], actN, {32'd28, 16'h9998}); end
    tick();
    compared++; if (tsN[47:0] !== {32'd34, 16'hFFFE}) begin mismatched++; $display("[TB] FAIL adj_done actual=%h required=%h", tsN[47:0], {32'd34, 16'hFFFE}); end
    input_adj_count = 16'd0;
    input_adj_valid = 1'b1;
    tick();
    input_adj_valid = 1'b0;
    compared++; if (tsN[47:0] !== {32'd41, 16'h6664} || actN !== 1'b0) begin mismatched++; $display("[TB] FAIL adj_zero actual=%h/%b required=%h/0", tsN[47:0], actN, {32'd41, 16'h6664}); end
  endtask

  task automatic test_adjust_negative();
    doReset();
    input_ts_96 = {48'd10, 32'd2, 16'h0000};
    input_ts_96_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    input_adj_ns = 32'hFFFF_FFEC;
    input_adj_fns = 16'h0000;
    input_adj_count = 16'd1;
    input_adj_valid = 1'b1;
    tick();
    input_adj_valid = 1'b0;
    compared++; if (tsN !== {48'd10, 32'd8, 16'h6666} || actN !== 1'b1) begin mismatched++; $display("[TB] FAIL neg_start actual=%h/%b required=%h/1", tsN, actN, {48'd10, 32'd8, 16'h6666}); end
    tick();
    compared++; if (tsN !== {48'd9, 32'd999_999_994, 16'hCCCC}) begin mismatched++; $display("[TB] FAIL neg_borrow actual=%h required=%h", tsN, {48'd9, 32'd999_999_994, 16'hCCCC}); end
    compared++; if ({ppsN, actN} !== 2'b00) begin mismatched++; $display("[TB] FAIL neg_flags actual=%b required=00", {ppsN, actN}); end
  endtask

  task automatic test_set_period();
    doReset();
    input_ts_96 = {48'd1, 32'd100, 16'h0000};
    input_ts_96_valid = 1'b1;
    input_period_ns = 4'd8;
    input_period_fns = 16'h8000;
    input_period_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    input_period_valid = 1'b0;
    compared++; if (tsN !== {48'd1, 32'd100, 16'h0000} || stepN !== 1'b1) begin mismatched++; $display("[TB] FAIL setper_set actual=%h/%b required=%h/1", tsN, stepN, {48'd1, 32'd100, 16'h0000}); end
    tick();
    compared++; if (tsN !== {48'd1, 32'd108, 16'h8000} || stepN !== 1'b0) begin mismatched++; $display("[TB] FAIL setper_first actual=%h/%b required=%h/0", tsN, stepN, {48'd1, 32'd108, 16'h8000}); end
    tick();
    compared++; if (tsN !== {48'd1, 32'd117, 16'h0000}) begin mismatched++; $display("[TB] FAIL setper_second actual=%h required=%h", tsN, {48'd1, 32'd117, 16'h0000}); end
  endtask

  task automatic test_set_abort();
    doReset();
    input_adj_ns = 32'd1;
    input_adj_fns = 16'h0000;
    input_adj_count = 16'd5;
    input_adj_valid = 1'b1;
    tick();
    input_adj_valid = 1'b0;
    tick();
    compared++; if (actN !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_active actual=%b required=1", actN); end
    input_ts_96 = {48'd7, 32'd1000, 16'h0000};
    input_ts_96_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    compared++; if (tsN !== {48'd7, 32'd1000, 16'h0000} || actN !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_set actual=%h/%b required=%h/0", tsN, actN, {48'd7, 32'd1000, 16'h0000}); end
    tick();
    compared++; if (tsN !== {48'd7, 32'd1006, 16'h6666} || actN !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_after actual=%h/%b required=%h/0", tsN, actN, {48'd7, 32'd1006, 16'h6666}); end
  endtask

  task automatic test_wrap();
    doReset();
    input_ts_96 = {48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0000};
    input_ts_96_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    compared++; if (tsN !== {48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0000} || ppsN !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_set actual=%h/%b required=%h/0", tsN, ppsN, {48'hFFFF_FFFF_FFFF, 32'd999_999_999, 16'h0000}); end
    tick();
    compared++; if (tsN !== {48'd0, 32'd5, 16'h6666} || ppsN !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_sec actual=%h/%b required=%h/1", tsN, ppsN, {48'd0, 32'd5, 16'h6666}); end
  endtask

  task automatic test_verbatim();
    doReset();
    input_ts_96 = {48'd3, 32'd1_500_000_000, 16'h0000};
    input_ts_96_valid = 1'b1;
    tick();
    input_ts_96_valid = 1'b0;
    compared++; if (tsN !== {48'd3, 32'd1_500_000_000, 16'h0000}) begin mismatched++; $display("[TB] FAIL verb_set actual=%h required=%h", tsN, {48'd3, 32'd1_500_000_000, 16'h0000}); end
    tick();
    compared++; if (tsN !== {48'd4, 32'd500_000_006, 16'h6666} || ppsN !== 1'b1) begin mismatched++; $display("[TB] FAIL verb_norm actual=%h/%b required=%h/1", tsN, ppsN, {48'd4, 32'd500_000_006, 16'h6666}); end
    tick();
    compared++; if (tsN !== {48'd4, 32'd500_000_012, 16'hCCCC} || ppsN !== 1'b0) begin mismatched++; $display("[TB] FAIL verb_after actual=%h/%b required=%h/0", tsN, ppsN, {48'd4, 32'd500_000_012, 16'hCCCC}); end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_drift();
    test_adjust();
    test_adjust_negative();
    test_set_period();
    test_set_abort();
    test_wrap();
    test_verbatim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
